// File: rtl/bounce_gen_amisha.sv
// Switch-bounce emulator.
// Turns a clean level request into a mechanically realistic bouncy switch
// signal. The first edge follows the request at once. A train of glitch
// pairs with LFSR-jittered spacing follows, and then a settle period ends
// the sequence. It drives the debouncer in self-test and in end-to-end benches.
module bounce_gen_amisha #(
    parameter int N_BOUNCE = 3,   // away-and-back glitch pairs after the first edge (0..15)
    parameter int MIN_GAP  = 4,   // minimum hold of every bouncy level (>= 1)
    parameter int GAP_W    = 3,   // width of the random gap extension (1..8)
    parameter int RAND_EN  = 1,   // 1: LFSR-extended gaps, 0: fixed MIN_GAP
    parameter int SETTLE   = 16   // hold of the final level before done (>= 1)
) (
    input  logic clk_amisha,
    input  logic reset_amisha,
    input  logic level_amisha,
    input  logic en_amisha,
    output logic sw_amisha,
    output logic busy_amisha,
    output logic done_amisha
);

    // One shared down-counter times both the gaps and the settle period.
    // It must be wide enough for the longer of the two.
    localparam int GAP_MAX = MIN_GAP + (1 << GAP_W) - 1;
    localparam int CNT_MAX = (GAP_MAX > SETTLE) ? GAP_MAX : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TOG_W   = 5;   // 2*15 toggles fit in five bits

    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [TOG_W-1:0] TOG_TARGET = TOG_W'(2 * N_BOUNCE);
    localparam logic [7:0]       LFSR_SEED  = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GAP    = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             sw_reg, sw_next;
    logic             target_reg, target_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [TOG_W-1:0] tog_reg, tog_next;
    logic [TOG_W-1:0] tog_inc;
    logic             busy_reg;
    logic             done_reg, done_next;
    logic [7:0]       lfsr_reg;
    logic             lfsr_fb;
    logic [CNT_W-1:0] gap_value;

    // The upper LFSR bits only matter for the sequence itself.
    // With RAND_EN=0 the register feeds nothing.
    logic             lfsr_unused;
    assign lfsr_unused = ^lfsr_reg;

    // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1.
    assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    // Free-running LFSR: it advances every cycle, so the gap value depends
    // on when the gap is loaded, not only on how many gaps came before.
    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
        end
    end

    // Gap length sampled whenever the counter is reloaded for a new level.
    generate
        if (RAND_EN != 0) begin : g_rand_gap
            assign gap_value = CNT_W'(MIN_GAP) + CNT_W'(lfsr_reg[GAP_W-1:0]);
        end else begin : g_fixed_gap
            assign gap_value = CNT_W'(MIN_GAP);
        end
    endgenerate

    assign tog_inc = tog_reg + 5'd1;

    // Next-state logic. A running sequence ignores level and en, so it
    // always finishes on target before a new request is looked at.
    always_comb begin
        state_next  = state_reg;
        sw_next     = sw_reg;
        target_next = target_reg;
        cnt_next    = cnt_reg;
        tog_next    = tog_reg;
        done_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (level_amisha != sw_reg) begin
                    sw_next     = level_amisha;
                    target_next = level_amisha;
                    if (en_amisha) begin
                        tog_next = '0;
                        if (N_BOUNCE == 0) begin
                            state_next = S_SETTLE;
                            cnt_next   = SETTLE_CNT;
                        end else begin
                            state_next = S_GAP;
                            cnt_next   = gap_value;
                        end
                    end else begin
                        // Pass-through mode: a clean edge that completes at once.
                        done_next = 1'b1;
                    end
                end
            end

            S_GAP: begin
                if (cnt_reg == CNT_ONE) begin
                    sw_next  = ~sw_reg;
                    tog_next = tog_inc;
                    // An even toggle count puts sw back on target, so the last
                    // glitch pair is complete once the count reaches 2*N_BOUNCE.
                    if (tog_inc == TOG_TARGET) begin
                        state_next = S_SETTLE;
                        cnt_next   = SETTLE_CNT;
                    end else begin
                        cnt_next = gap_value;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            S_SETTLE: begin
                sw_next = target_reg;
                if (cnt_reg == CNT_ONE) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers. busy is derived from the next state so
    // that it is high exactly while the registered state is not IDLE.
    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            state_reg  <= S_IDLE;
            sw_reg     <= 1'b0;
            target_reg <= 1'b0;
            cnt_reg    <= '0;
            tog_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sw_reg     <= sw_next;
            target_reg <= target_next;
            cnt_reg    <= cnt_next;
            tog_reg    <= tog_next;
            busy_reg   <= (state_next != S_IDLE);
            done_reg   <= done_next;
        end
    end

    assign sw_amisha   = sw_reg;
    assign busy_amisha = busy_reg;
    assign done_amisha = done_reg;

endmodule

// File: tb/tb_bounce_gen_amisha.sv
// Bench for bounce_gen_amisha. It drives three instances from one clock:
//   dut_a: fixed gaps, N_BOUNCE=3, used for the exact-timing scenarios
//   dut_b: N_BOUNCE=0, no glitches at all
//   dut_c: defaults (random gaps), used for the randomized level changes
// Expected sw edges and done pulses go into per-instance queues when the
// stimulus is driven. Monitors pop them when the DUT shows the event.
module tb_bounce_gen_amisha;

    localparam int GAP = 4;
    localparam int SET = 16;
    localparam int NB  = 3;
    localparam int SEQ_LEN = GAP * 2 * NB + SET;   // edge of done relative to E0

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after the posedge numbered k, cyc reads k at the negedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_asserts = 0;
    int n_fail    = 0;

    logic rst_a, lvl_a, en_a, sw_a, busy_a, done_a;
    logic rst_b, lvl_b, en_b, sw_b, busy_b, done_b;
    logic rst_c, lvl_c, en_c, sw_c, busy_c, done_c;

    ev_t  qa_sw[$];
    int   qa_done[$];
    ev_t  qb_sw[$];
    int   qb_done[$];
    logic qc_lvl[$];
    int   c_done_cnt = 0;

    bounce_gen_amisha #(.N_BOUNCE(3), .MIN_GAP(4), .GAP_W(3), .RAND_EN(0), .SETTLE(16)) dut_a (
        .clk_amisha(clk), .reset_amisha(rst_a), .level_amisha(lvl_a), .en_amisha(en_a),
        .sw_amisha(sw_a), .busy_amisha(busy_a), .done_amisha(done_a));

    bounce_gen_amisha #(.N_BOUNCE(0), .MIN_GAP(4), .GAP_W(3), .RAND_EN(0), .SETTLE(16)) dut_b (
        .clk_amisha(clk), .reset_amisha(rst_b), .level_amisha(lvl_b), .en_amisha(en_b),
        .sw_amisha(sw_b), .busy_amisha(busy_b), .done_amisha(done_b));

    bounce_gen_amisha dut_c (
        .clk_amisha(clk), .reset_amisha(rst_c), .level_amisha(lvl_c), .en_amisha(en_c),
        .sw_amisha(sw_c), .busy_amisha(busy_c), .done_amisha(done_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Expected sw edges of a full N_BOUNCE=3 fixed-gap sequence and its done pulse.
    task automatic push_seq_a(input int e0, input logic tgt);
        ev_t e;
        for (int t = 0; t <= 2 * NB; t++) begin
            e.cyc = e0 + GAP * t;
            e.val = (t % 2 == 0) ? tgt : ~tgt;
            qa_sw.push_back(e);
        end
        qa_done.push_back(e0 + SEQ_LEN);
    endtask

    task automatic push_edge_a(input int c, input logic v, input logic with_done);
        ev_t e;
        e.cyc = c;
        e.val = v;
        qa_sw.push_back(e);
        if (with_done) qa_done.push_back(c);
    endtask

    // Monitor for dut_a: every sw change and every done-high cycle must match the queue head.
    initial begin
        logic prev;
        ev_t  e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_a !== 1'b1) begin
                prev = sw_a;
            end else begin
                if (sw_a !== prev) begin
                    if (qa_sw.size() == 0) begin
                        check("a_sw_unexpected_at_cyc", cyc, -1);
                    end else begin
                        e = qa_sw.pop_front();
                        check("a_sw_edge_cyc", cyc, e.cyc);
                        check("a_sw_edge_val", {31'd0, sw_a}, {31'd0, e.val});
                    end
                    prev = sw_a;
                end
                if (done_a === 1'b1) begin
                    if (qa_done.size() == 0) check("a_done_unexpected_at_cyc", cyc, -1);
                    else                     check("a_done_cyc", cyc, qa_done.pop_front());
                end
            end
        end
    end

    // Monitor for dut_b.
    initial begin
        logic prev;
        ev_t  e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_b !== 1'b1) begin
                prev = sw_b;
            end else begin
                if (sw_b !== prev) begin
                    if (qb_sw.size() == 0) begin
                        check("b_sw_unexpected_at_cyc", cyc, -1);
                    end else begin
                        e = qb_sw.pop_front();
                        check("b_sw_edge_cyc", cyc, e.cyc);
                        check("b_sw_edge_val", {31'd0, sw_b}, {31'd0, e.val});
                    end
                    prev = sw_b;
                end
                if (done_b === 1'b1) begin
                    if (qb_done.size() == 0) check("b_done_unexpected_at_cyc", cyc, -1);
                    else                     check("b_done_cyc", cyc, qb_done.pop_front());
                end
            end
        end
    end

    // Monitor for dut_c. It checks the hold time of every bouncy level and
    // counts the glitch toggles. At done it compares sw with the requested level.
    initial begin
        logic sw_prev, busy_prev;
        int   last_edge, tog, hold;
        logic exp_lvl;
        sw_prev   = 1'b0;
        busy_prev = 1'b0;
        last_edge = 0;
        tog       = 0;
        forever begin
            @(negedge clk);
            if (rst_c !== 1'b1) begin
                sw_prev   = sw_c;
                busy_prev = busy_c;
            end else begin
                if (sw_c !== sw_prev) begin
                    if (busy_c === 1'b1 && busy_prev !== 1'b1) begin
                        tog = 0;
                    end else begin
                        hold = cyc - last_edge;
                        n_asserts++;
                        assert (hold >= GAP && hold <= GAP + 7) else begin
                            n_fail++;
                            $error("FAIL c_gap_hold: observed %0d expected %0d..%0d", hold, GAP, GAP + 7);
                        end
                        tog++;
                    end
                    last_edge = cyc;
                    sw_prev   = sw_c;
                end
                if (done_c === 1'b1) begin
                    c_done_cnt++;
                    check("c_toggles", tog, 2 * NB);
                    if (qc_lvl.size() == 0) begin
                        check("c_done_unexpected_at_cyc", cyc, -1);
                    end else begin
                        exp_lvl = qc_lvl.pop_front();
                        check("c_final_sw", {31'd0, sw_c}, {31'd0, exp_lvl});
                    end
                end
                busy_prev = busy_c;
            end
        end
    end

    initial begin
        int e0;
        int t0;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        lvl_a = 1'b0; lvl_b = 1'b0; lvl_c = 1'b0;
        en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #1;
        check("rst_sw_a",   {31'd0, sw_a},   0);
        check("rst_busy_a", {31'd0, busy_a}, 0);
        check("rst_done_a", {31'd0, done_a}, 0);
        check("rst_sw_c",   {31'd0, sw_c},   0);
        repeat (3) @(negedge clk);
        #1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        @(negedge clk);

        // Fixed-gap bounce sequence 0 -> 1.
        lvl_a = 1'b1;
        e0 = cyc + 1;
        push_seq_a(e0, 1'b1);
        wait_cyc(e0);
        check("s1_busy_at_E0", {31'd0, busy_a}, 1);
        wait_cyc(e0 + SEQ_LEN - 1);
        check("s1_busy_before_done", {31'd0, busy_a}, 1);
        wait_cyc(e0 + SEQ_LEN);
        check("s1_busy_at_done", {31'd0, busy_a}, 0);
        wait_cyc(e0 + SEQ_LEN + 4);
        check("s1_queue_empty", qa_sw.size() + qa_done.size(), 0);
        check("s1_final_sw", {31'd0, sw_a}, 1);

        // Pass-through mode: each change follows after one edge with a done pulse.
        en_a  = 1'b0;
        lvl_a = 1'b0;
        e0 = cyc + 1;
        push_edge_a(e0, 1'b0, 1'b1);
        wait_cyc(e0);
        check("s2_busy_first", {31'd0, busy_a}, 0);
        wait_cyc(e0 + 4);
        lvl_a = 1'b1;
        push_edge_a(e0 + 5, 1'b1, 1'b1);
        wait_cyc(e0 + 5);
        check("s2_busy_second", {31'd0, busy_a}, 0);
        wait_cyc(e0 + 9);
        lvl_a = 1'b0;
        push_edge_a(e0 + 10, 1'b0, 1'b1);
        wait_cyc(e0 + 14);
        check("s2_queue_empty", qa_sw.size() + qa_done.size(), 0);
        check("s2_final_sw", {31'd0, sw_a}, 0);
        en_a = 1'b1;

        // The request reverts mid-sequence. The sequence finishes unchanged,
        // and a new one starts on the very next edge.
        lvl_a = 1'b1;
        e0 = cyc + 1;
        push_seq_a(e0, 1'b1);
        wait_cyc(e0 + 9);
        lvl_a = 1'b0;
        push_seq_a(e0 + SEQ_LEN + 1, 1'b0);
        wait_cyc(e0 + SEQ_LEN);
        check("s3_busy_at_first_done", {31'd0, busy_a}, 0);
        wait_cyc(e0 + SEQ_LEN + 1);
        check("s3_busy_restart", {31'd0, busy_a}, 1);
        wait_cyc(e0 + 2 * SEQ_LEN + 5);
        check("s3_queue_empty", qa_sw.size() + qa_done.size(), 0);
        check("s3_final_sw", {31'd0, sw_a}, 0);

        // Reset mid-sequence: outputs clear at once, and no done pulse follows.
        lvl_a = 1'b1;
        e0 = cyc + 1;
        push_seq_a(e0, 1'b1);
        wait_cyc(e0 + 10);
        #1;
        rst_a = 1'b0;
        #1;
        check("s4_rst_sw",   {31'd0, sw_a},   0);
        check("s4_rst_busy", {31'd0, busy_a}, 0);
        check("s4_rst_done", {31'd0, done_a}, 0);
        qa_sw.delete();
        qa_done.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_a = 1'b1;
        e0 = cyc + 1;
        push_seq_a(e0, 1'b1);
        wait_cyc(e0);
        check("s4_restart_busy", {31'd0, busy_a}, 1);
        wait_cyc(e0 + SEQ_LEN + 4);
        check("s4_queue_empty", qa_sw.size() + qa_done.size(), 0);
        check("s4_final_sw", {31'd0, sw_a}, 1);

        // No glitches: first edge, then only the settle period.
        begin
            ev_t e;
            lvl_b = 1'b1;
            e0 = cyc + 1;
            e.cyc = e0;
            e.val = 1'b1;
            qb_sw.push_back(e);
            qb_done.push_back(e0 + SET);
        end
        wait_cyc(e0);
        check("s5_busy_at_E0", {31'd0, busy_b}, 1);
        wait_cyc(e0 + SET);
        check("s5_busy_at_done", {31'd0, busy_b}, 0);
        wait_cyc(e0 + SET + 4);
        check("s5_queue_empty", qb_sw.size() + qb_done.size(), 0);
        check("s5_final_sw", {31'd0, sw_b}, 1);

        // Random gaps: 50 level changes, each after the previous sequence is done.
        for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            lvl_c = ~lvl_c;
            qc_lvl.push_back(lvl_c);
            t0 = cyc;
            while (c_done_cnt < i + 1 && cyc - t0 < 400) @(negedge clk);
            check("c_done_seen", c_done_cnt, i + 1);
        end
        repeat (3) @(negedge clk);
        check("c_queue_empty", qc_lvl.size(), 0);
        check("c_busy_idle", {31'd0, busy_c}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/bounce_gen_amisha.md
Name: bounce_gen_amisha

Overview:
Switch-bounce emulator, the stimulus-side counterpart of the team's debounce FSM. It takes a clean level request and drives a mechanically realistic bouncy switch signal. Each level change produces a burst of glitches with programmable and optionally pseudo-random spacing, then a settle period. The block is used in on-board self-test and in benches that exercise the debouncer end to end.

Parameters:
N_BOUNCE, 3, number of away-and-back glitch pairs after the first edge; range 0..15.
MIN_GAP, 4, minimum cycles each bouncy level is held; must be ≥1.
GAP_W, 3, width of the random gap extension; gap range is MIN_GAP..MIN_GAP+2^GAP_W-1.
RAND_EN, 1, 1 selects LFSR-extended gaps; 0 gives a fixed gap of MIN_GAP.
SETTLE, 16, cycles the final level is held before done; must be ≥1.

Ports:
clk_amisha  in  1  system clock, rising-edge.
reset_amisha  in  1  asynchronous, active-low reset.
level_amisha  in  1  clean requested switch level.
en_amisha  in  1  1 enables bounce emulation; 0 makes the output follow directly.
sw_amisha  out  1  emulated bouncy switch output, registered.
busy_amisha  out  1  high while a bounce sequence is in progress (state ≠ IDLE).
done_amisha  out  1  one-cycle pulse when the output has reached the target and is stable.

Behaviour:
- Reset (reset_amisha=0, asynchronous): sw_amisha=0, busy_amisha=0, done_amisha=0, state=IDLE, LFSR=8'hA5, all counters cleared.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every cycle outside reset.
  - gap = MIN_GAP + (RAND_EN ? lfsr[GAP_W-1:0] : 0), sampled each time a gap is loaded.
- States: IDLE, GAP, SETTLE.
- IDLE:
  - When level_amisha ≠ sw_amisha and en_amisha=0: at the next edge sw_amisha←level_amisha and done_amisha=1 for that cycle. Stay in IDLE; busy stays 0.
  - When level_amisha ≠ sw_amisha and en_amisha=1: at the next edge sw_amisha←level_amisha (first edge) and target←level_amisha. Load gap_cnt←gap and toggles←0, then go to GAP, or to SETTLE if N_BOUNCE=0.
- GAP:
  - gap_cnt decrements each cycle.
  - At the edge where gap_cnt==1: toggle sw_amisha, increment toggles, reload gap_cnt←gap.
  - Each intermediate sw level is therefore held exactly gap cycles.
  - When the toggle just performed makes toggles==2*N_BOUNCE (sw back at target): go to SETTLE and load settle_cnt←SETTLE.
- SETTLE:
  - sw_amisha is held at target; settle_cnt decrements.
  - At the edge where settle_cnt==1: go to IDLE and assert done_amisha for exactly one cycle.
- busy_amisha is high in GAP and SETTLE, low in IDLE. It is registered with the state.
- level_amisha and en_amisha are ignored outside IDLE; a sequence is never aborted by them.
  - On return to IDLE, a level that differs from sw_amisha immediately starts a new sequence, with the same timing as a fresh request.
  - The done pulse still occurs on the return to IDLE.
- sw_amisha always ends a sequence equal to target. Glitches always alternate away from target and back to it.
- Reset mid-sequence: immediate return to the reset values. No done pulse is generated.

Test Plan:
- RAND_EN=0, MIN_GAP=4, N_BOUNCE=3, SETTLE=16, en=1; level 0→1 sampled at edge E0 → sw rises at E0. sw toggles at E4, E8, E12, E16, E20, E24 (final level 1). busy is high E0..E40. done is high for one cycle starting at E40. sw=1 thereafter.
- en=0, level toggles 0→1→0 with 5-cycle spacing → sw follows with 1-cycle latency. done pulses on each change. busy stays 0.
- Same parameters as the first scenario; level returns 1→0 at E10, mid-sequence → E0..E40 sequence completes unchanged with final sw=1. A new sequence to 0 starts at E41 and completes with done at E81.
- Reset asserted at E10 of a sequence → sw=0, busy=0, done=0 immediately. With level still 1, a fresh sequence starts on the first edge after reset release.
- RAND_EN=1, defaults, 50 random level changes → every intermediate hold lasts 4..11 cycles. Each sequence has exactly 6 toggles after the first edge. The final sw equals the requested level.
- N_BOUNCE=0, level 0→1 at E0 → sw rises at E0, no glitches, done at E16.
